inv_sub_bytes: RTL

Inverse SubBytes stage for the AES decryption datapath. It accepts one 128-bit AES state over a valid/ready handshake and replaces every byte with its inverse S-box value (FIPS-197 InvSbox). It processes `BYTES_PER_CYCLE` bytes per clock, trading latency for area, and presents the result through a registered valid/ready output. It sits between InvShiftRows and AddRoundKey in the decryption round controller.

---
 rtl/inv_sub_bytes.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes.sv
// Inverse SubBytes for the AES decryption round: BYTES_PER_CYCLE table lookups per clock.
// Optional macro INV_SUB_BYTES_FWD_EN adds a mode input that selects the forward S-box.
module inv_sub_bytes #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
`ifdef INV_SUB_BYTES_FWD_EN
   input  logic         mode,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   localparam int N     = 16 / BYTES_PER_CYCLE;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   generate
      if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
          BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
         $error("inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   // Byte a of a table sits at bits [2047-8a -: 8], i.e. top index {~a, 3'b111}.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_lut(input logic [7:0] a);
      return INV_SBOX[{~a, 3'b111} -: 8];
   endfunction

`ifdef INV_SUB_BYTES_FWD_EN
   localparam logic [2047:0] FWD_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] fwd_lut(input logic [7:0] a);
      return FWD_SBOX[{~a, 3'b111} -: 8];
   endfunction

   logic mode_q;
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;

   logic [IDX_W-1:0] idx;
   logic [7:0] in_b [16];
   logic [7:0] hold [16];
   logic [7:0] res  [16];
   logic [3:0] lane_pos [BYTES_PER_CYCLE];
   logic [7:0] lane_out [BYTES_PER_CYCLE];

   // Byte i of the packed state is the most-significant-first byte i.
   for (genvar i = 0; i < 16; i++) begin : g_bytes
      assign in_b[i] = in_state[127-8*i -: 8];
      assign out_state[127-8*i -: 8] = res[i];
   end

   for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
      assign lane_pos[j] = 4'(int'(idx) * BYTES_PER_CYCLE + j);
`ifdef INV_SUB_BYTES_FWD_EN
      assign lane_out[j] = mode_q ? fwd_lut(hold[lane_pos[j]]) : inv_lut(hold[lane_pos[j]]);
`else
      assign lane_out[j] = inv_lut(hold[lane_pos[j]]);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (idx == IDX_LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         for (int i = 0; i < 16; i++) begin
            hold[i] <= 8'h00;
            res[i]  <= 8'h00;
         end
`ifdef INV_SUB_BYTES_FWD_EN
         mode_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               hold <= in_b;
               idx  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
               mode_q <= mode;
`endif
            end
            BUSY: begin
               for (int j = 0; j < BYTES_PER_CYCLE; j++) res[lane_pos[j]] <= lane_out[j];
               idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
